uart_tx_ctrl: RTL and testbench

//  Sequences the uart_transmitter for the CPU output path. Buffers CPU byte writes in a FIFO and issues one

---
 rtl/uart_tx_ctrl_pkg.sv | 20 ++
 rtl/uart_tx_ctrl_sync_fifo.sv | 75 +++++++
 rtl/uart_tx_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl_pkg
// Purpose  : Shared types and constants for the UART transmit sequencer.
//            Holds the controller state encoding and the tx_data reset value.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_ctrl_pkg;

  localparam int unsigned c_DATA_W      = 8;
  localparam logic [7:0]  c_TX_DATA_RST = 8'h00;

  typedef enum logic [1:0] {
    S_TXC_IDLE   = 2'd0,
    S_TXC_LAUNCH = 2'd1,
    S_TXC_WAIT   = 2'd2
  } uart_tx_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with show-ahead read data and a flush input.
//            The pointers wrap modulo DEPTH, and the occupancy count is kept
//            in its own register so that full/empty need no pointer compare.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            push_i/data_i - write strobe and data (ignored when full)
//            pop_i         - consume head entry (ignored when empty)
//            flush_i       - discard all entries; overrides push and pop
//            data_o        - current head entry (show-ahead)
//            count_o       - occupancy 0..DEPTH
//            full_o/empty_o- occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0]   c_FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == c_FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push while full is dropped even if a pop lands in the same cycle.
  assign w_push = push_i && !full_o  && !flush_i;
  assign w_pop  = pop_i  && !empty_o && !flush_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_CNT_ONE;
        2'b01:   count_q <= count_q - c_CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : Queues CPU output bytes and feeds them one at a time to the
//            UART transmitter, issuing one start strobe per byte and waiting
//            for the transmitter to go idle before the next.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            wr_en, wr_data       - CPU byte write
//            flush                - drop queued bytes (frame in flight finishes)
//            ovf_clear            - clear sticky overflow
//            tx_busy              - transmitter busy flag
//            tx_data, tx_start    - to transmitter data_in / start_strobe
//            fifo_count/full/empty, overflow, ctrl_idle - CPU status
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [c_DATA_W-1:0] wr_data,
  input  logic                flush,
  input  logic                ovf_clear,
  input  logic                tx_busy,
  output logic [c_DATA_W-1:0] tx_data,
  output logic                tx_start,
  output logic [AW:0]         fifo_count,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                overflow,
  output logic                ctrl_idle
);

  uart_tx_ctrl_state_t state_q, state_d;
  logic [c_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                overflow_q, overflow_d;
  logic                wait_first_q, wait_first_d;
  logic [c_DATA_W-1:0] w_head;
  logic                w_pop;
  logic                w_ovf_set;

  sync_fifo #(
    .WIDTH (c_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (wr_en),
    .data_i  (wr_data),
    .pop_i   (w_pop),
    .flush_i (flush),
    .data_o  (w_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_TXC_IDLE;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_first_q <= wait_first_d;
    end
  end

  // Next-state logic. A flush in the launch-decision cycle wins over the pop
  // so that a discarded byte can never be started.
  always_comb begin
    state_d      = state_q;
    w_pop        = 1'b0;
    wait_first_d = (state_q == S_TXC_LAUNCH);
    case (state_q)
      S_TXC_IDLE: begin
        if (!fifo_empty && !tx_busy && !flush) begin
          w_pop   = 1'b1;
          state_d = S_TXC_LAUNCH;
        end
      end
      S_TXC_LAUNCH: state_d = S_TXC_WAIT;
      S_TXC_WAIT: begin
        // First WAIT cycle skipped: the transmitter may not yet reflect the strobe.
        if (!wait_first_q && !tx_busy) state_d = S_TXC_IDLE;
      end
      default: state_d = S_TXC_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    tx_start = (state_q == S_TXC_LAUNCH);
  end

  // Datapath: launched byte and sticky overflow (a new drop beats a clear).
  assign tx_data_d  = w_pop ? w_head : tx_data_q;
  assign w_ovf_set  = wr_en && fifo_full && !flush;
  assign overflow_d = w_ovf_set || (overflow_q && !ovf_clear);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data_q  <= c_TX_DATA_RST;
      overflow_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign overflow  = overflow_q;
  assign ctrl_idle = fifo_empty && (state_q == S_TXC_IDLE) && !tx_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Self-checking bench for uart_tx_ctrl. Contains a behavioural
//            UART transmitter (20 clk/bit, busy high combinationally in the
//            strobe cycle), a byte scoreboard and a strobe-spacing monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CPB   = 20;

  logic          clk = 1'b0;
  logic          reset, wr_en, flush, ovf_clear;
  logic [7:0]    wr_data;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty, overflow, ctrl_idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .flush      (flush),
    .ovf_clear  (ovf_clear),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .ctrl_idle  (ctrl_idle)
  );

  // ---------------- behavioural transmitter ----------------
  logic       m_busy;
  logic [9:0] m_sh;
  int         m_clk, m_bit;
  logic       serial;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_sh <= 10'h3FF; m_clk <= 0; m_bit <= 0;
    end else if (!m_busy) begin
      if (tx_start) begin
        m_busy <= 1'b1; m_sh <= {1'b1, tx_data, 1'b0}; m_clk <= 0; m_bit <= 0;
      end
    end else if (m_clk == CPB-1) begin
      m_clk <= 0;
      m_sh  <= {1'b1, m_sh[9:1]};
      if (m_bit == 9) m_busy <= 1'b0;
      else            m_bit  <= m_bit + 1;
    end else begin
      m_clk <= m_clk + 1;
    end
  end

  assign tx_busy = tx_start | m_busy;
  assign serial  = m_busy ? m_sh[0] : 1'b1;

  // ---------------- monitors ----------------
  logic [7:0] sent_q[$];
  logic       bits_q[$];
  logic [7:0] exp_q[$];
  int         low_run;
  int         proto_err = 0;

  always @(posedge clk) begin
    if (reset) begin
      low_run <= 100;
    end else begin
      if (tx_start) begin
        sent_q.push_back(tx_data);
        if (low_run < 2) proto_err <= proto_err + 1;
      end
      if (m_busy && m_clk == CPB/2) bits_q.push_back(serial);
      low_run <= tx_busy ? 0 : ((low_run < 100) ? low_run + 1 : low_run);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; ovf_clear = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!ctrl_idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, ctrl_idle, 1);
  endtask

  task automatic check_frame(input logic [7:0] b, input string name);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    chk({name, "_nbits"}, bits_q.size(), 10);
    for (int i = 0; i < 10 && i < bits_q.size(); i++)
      chk($sformatf("%s_bit%0d", name, i), bits_q[i], fr[i]);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       fl;
    logic       clr;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_ovf;
    logic       e_start;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsent;
    int n;
    // Burst 41,42,43: pop of 41 coincides with push of 42, so the count holds at 1 then peaks at 2.
    vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    idle_inputs();

    // 1: reset state
    repeat (10) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_idle", ctrl_idle, 1);
    chk("rst_tx_data", tx_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // 2: single byte, latency and serial waveform
    bits_q.delete();
    wr_en = 1'b1; wr_data = 8'hAA;
    @(negedge clk);
    idle_inputs();
    chk("t2_lat1_start", tx_start, 0);
    @(negedge clk);
    chk("t2_lat2_start", tx_start, 1);
    chk("t2_tx_data", tx_data, 8'hAA);
    @(negedge clk);
    chk("t2_one_cycle", tx_start, 0);
    exp_q.push_back(8'hAA);
    wait_idle(400, "t2_idle");
    check_frame(8'hAA, "t2");

    // 3: table-driven burst
    for (int i = 0; i < 4; i++) begin
      wr_en = vecs[i].wr; wr_data = vecs[i].data;
      flush = vecs[i].fl; ovf_clear = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("t3_v%0d_count", i), fifo_count, vecs[i].e_count);
      chk($sformatf("t3_v%0d_empty", i), fifo_empty, vecs[i].e_empty);
      chk($sformatf("t3_v%0d_ovf", i), overflow, vecs[i].e_ovf);
      chk($sformatf("t3_v%0d_start", i), tx_start, vecs[i].e_start);
    end
    idle_inputs();
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    wait_idle(1000, "t3_idle");

    // 4: overflow with the transmitter busy
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
      @(negedge clk);
    end
    idle_inputs();
    chk("t4_count_full", fifo_count, DEPTH);
    chk("t4_full", fifo_full, 1);
    chk("t4_ovf", overflow, 1);
    wr_en = 1'b1; wr_data = 8'hDD; ovf_clear = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("t4_set_beats_clear", overflow, 1);
    chk("t4_count_hold", fifo_count, DEPTH);
    ovf_clear = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("t4_ovf_cleared", overflow, 0);
    n = 0;
    while (tx_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t4_busy_drop", tx_busy, 0);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hEE;       // sampled on the pop edge
    @(negedge clk);
    idle_inputs();
    chk("t4_pop_write_count", fifo_count, DEPTH - 1);
    chk("t4_pop_write_ovf", overflow, 1);
    chk("t4_pop_launch", tx_start, 1);
    chk("t4_pop_tx_data", tx_data, 8'h51);
    exp_q.push_back(8'h50); exp_q.push_back(8'h51);
    flush = 1'b1; ovf_clear = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("t4_flush_count", fifo_count, 0);
    chk("t4_ovf_clear2", overflow, 0);
    wait_idle(400, "t4_idle");

    // 5: flush mid-frame with 5 queued, concurrent write dropped silently
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h61 + 8'(i);
      @(negedge clk);
    end
    idle_inputs();
    chk("t5_queued", fifo_count, 5);
    repeat (50) @(negedge clk);
    nsent = sent_q.size();
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    idle_inputs();
    chk("t5_flush_count", fifo_count, 0);
    chk("t5_flush_empty", fifo_empty, 1);
    chk("t5_flush_no_ovf", overflow, 0);
    chk("t5_frame_continues", tx_busy, 1);
    exp_q.push_back(8'h61);
    wait_idle(400, "t5_idle");
    chk("t5_no_more_start", sent_q.size(), nsent);

    // 6: reset during a data bit
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk);
    wr_data = 8'h5B;
    @(negedge clk);
    idle_inputs();
    repeat (60) @(negedge clk);
    chk("t6_busy_before", tx_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_start", tx_start, 0);
    chk("t6_empty", fifo_empty, 1);
    chk("t6_count", fifo_count, 0);
    chk("t6_tx_data", tx_data, 8'h00);
    chk("t6_serial", serial, 1);
    chk("t6_idle", ctrl_idle, 1);
    exp_q.push_back(8'h5A);
    bits_q.delete();
    wr_en = 1'b1; wr_data = 8'hC3;
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(8'hC3);
    repeat (3) @(negedge clk);
    wait_idle(400, "t6_idle");
    check_frame(8'hC3, "t6");

    // scoreboard and strobe spacing
    chk("sb_count", sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk($sformatf("sb_byte%0d", i), sent_q[i], exp_q[i]);
    chk("strobe_spacing", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
